// File: rtl/ilog_unit_if.sv
// ----------------------------------------------------------------------------
// ilog_unit_if : request/response bundle for the ilog_unit coprocessor.
//
//   start   requester -> unit  request, sampled only while the unit is idle
//   mode    requester -> unit  0 = floor, 1 = ceil (captured with start)
//   base    requester -> unit  logarithm base (captured with start)
//   value   requester -> unit  argument (captured with start)
//   busy    unit -> requester  high whenever the unit is not idle
//   done    unit -> requester  one-cycle pulse: result/err valid
//   result  unit -> requester  computed exponent
//   err     unit -> requester  invalid-operand flag for result
//   pow_out unit -> requester  base^floor_result (only with ILOG_POW_OUT_EN)
//
// Optional feature macro: ILOG_POW_OUT_EN
// ----------------------------------------------------------------------------
interface ilog_unit_if #(
    parameter int W = 16
);
    localparam int RW = $clog2(W) + 1;

    logic          start;
    logic          mode;
    logic [W-1:0]  base;
    logic [W-1:0]  value;
    logic          busy;
    logic          done;
    logic [RW-1:0] result;
    logic          err;
`ifdef ILOG_POW_OUT_EN
    logic [W-1:0]  pow_out;
`endif

    modport master (
        output start, mode, base, value,
        input  busy, done, result, err
`ifdef ILOG_POW_OUT_EN
        , input pow_out
`endif
    );

    modport slave (
        input  start, mode, base, value,
        output busy, done, result, err
`ifdef ILOG_POW_OUT_EN
        , output pow_out
`endif
    );
endinterface

// File: rtl/ilog_unit.sv
// ----------------------------------------------------------------------------
// ilog_unit : iterative integer logarithm, floor or ceil of log_base(value).
// One multiply per cycle: pow is multiplied by base until the next product
// would exceed value; the number of successful steps is the floor result.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (abandons any running operation)
//   bus    ilog_unit_if.slave: start/mode/base/value in,
//          busy/done/result/err (and pow_out) out, all registered
//
// Optional feature macro: ILOG_POW_OUT_EN
//   defined   : bus.pow_out = final pow register (base^floor_result),
//               0 on the error path, valid with done
//   undefined : pow stays internal, everything else identical
// ----------------------------------------------------------------------------
module ilog_unit #(
    parameter int W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    ilog_unit_if.slave  bus
);
    localparam int RW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_v;
    logic [W-1:0]  r_pow;
    logic [RW-1:0] r_e;
    logic          r_m;
    logic          r_busy;
    logic          r_done;
    logic [RW-1:0] r_result;
    logic          r_err;

    logic [2*W-1:0] w_prod;
    logic           w_fits;
    logic           w_bad;

    // Full 2W-bit product so the compare against value never sees a
    // wrapped power (e.g. base 2 stepping past 2^W-1).
    assign w_prod = {{W{1'b0}}, r_pow} * {{W{1'b0}}, r_b};
    assign w_fits = (w_prod <= {{W{1'b0}}, r_v});
    // base < 2 or value == 0
    assign w_bad  = (r_b[W-1:1] == '0) || (r_v == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_b      <= '0;
            r_v      <= '0;
            r_pow    <= '0;
            r_e      <= '0;
            r_m      <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_b     <= bus.base;
                        r_v     <= bus.value;
                        r_m     <= bus.mode;
                        r_pow   <= {{(W-1){1'b0}}, 1'b1};
                        r_e     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    // Invalid operands still pass through one CALC cycle, so
                    // an error reports done two edges after start; the
                    // valid-operand check here can never fire for them.
                    if (w_bad) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_pow    <= '0;
                        r_done   <= 1'b1;
                        r_state  <= S_FIN;
                    end else if (w_fits) begin
                        r_pow <= w_prod[W-1:0];
                        r_e   <= r_e + 1'b1;
                    end else begin
                        // Ceil rounds up unless value is an exact power.
                        r_result <= (r_m && (r_pow != r_v)) ? r_e + 1'b1 : r_e;
                        r_err    <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_FIN;
                    end
                end
                S_FIN: begin
                    // start seen here is dropped; requester retries once idle
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.err    = r_err;
`ifdef ILOG_POW_OUT_EN
    assign bus.pow_out = r_pow;
`endif

endmodule
